// File: rtl/max_array_sched.sv
// Stage sequencer for a row of max_block reduction tiles.
// Takes one layer configuration, then for each stage pulses the tiles
// through START -> STREAM -> DRAIN -> GAP, gating exactly DATA_NUM input
// beats per stage and waiting for the row's max-result window to close.
module max_array_sched #(
  parameter int NUM_BLOCKS = 4,
  parameter int DATA_NUM   = 192,
  parameter int DRAIN_MAX  = 1023,
  parameter int GAP_CYC    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [7:0]              cfg_num_stages,
  input  logic [NUM_BLOCKS-1:0]   cfg_block_mask,
  input  logic [1:0]              cfg_sel,
  input  logic [1:0]              cfg_last_sel,
  input  logic                    abort,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    res_valid,
  output logic                    stage_start,
  output logic [NUM_BLOCKS-1:0]   block_en,
  output logic [2*NUM_BLOCKS-1:0] output_sel,
  output logic [7:0]              stage_idx,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_DRAIN,
    S_GAP
  } state_t;

  localparam logic [9:0] BEAT_LAST  = 10'(DATA_NUM - 1);
  localparam logic [9:0] DRAIN_LAST = 10'(DRAIN_MAX - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYC - 1);

  state_t                  state_q;
  logic [9:0]              beat_cnt_q;
  logic [9:0]              drain_cnt_q;
  logic [7:0]              gap_cnt_q;
  logic                    armed_q;      // res_valid seen high inside DRAIN
  logic [7:0]              last_idx_q;   // index of the final stage
  logic [NUM_BLOCKS-1:0]   mask_q;
  logic [1:0]              sel_q;
  logic [1:0]              last_sel_q;
  logic                    stage_start_q;
  logic [NUM_BLOCKS-1:0]   block_en_q;
  logic [2*NUM_BLOCKS-1:0] output_sel_q;
  logic [7:0]              stage_idx_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;

  // Spread one 2-bit select code onto every enabled block; disabled blocks get 0.
  function automatic logic [2*NUM_BLOCKS-1:0] sel_map(input logic [NUM_BLOCKS-1:0] mask,
                                                       input logic [1:0] field);
    logic [2*NUM_BLOCKS-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      if (mask[i]) r[2*i +: 2] = field;
    end
    return r;
  endfunction

  // Handshake readies decode straight from the state register.
  assign cfg_ready   = (state_q == S_IDLE);
  assign in_ready    = (state_q == S_STREAM);
  assign stage_start = stage_start_q;
  assign block_en    = block_en_q;
  assign output_sel  = output_sel_q;
  assign stage_idx   = stage_idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

  // Stage FSM; every registered output is loaded together with the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      beat_cnt_q    <= '0;
      drain_cnt_q   <= '0;
      gap_cnt_q     <= '0;
      armed_q       <= 1'b0;
      last_idx_q    <= '0;
      mask_q        <= '0;
      sel_q         <= '0;
      last_sel_q    <= '0;
      stage_start_q <= 1'b0;
      block_en_q    <= '0;
      output_sel_q  <= '0;
      stage_idx_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else if (abort) begin
      // Abandon the layer without a done pulse; err keeps its value.
      state_q       <= S_IDLE;
      beat_cnt_q    <= '0;
      drain_cnt_q   <= '0;
      gap_cnt_q     <= '0;
      armed_q       <= 1'b0;
      stage_start_q <= 1'b0;
      block_en_q    <= '0;
      output_sel_q  <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cfg_valid) begin
            last_idx_q    <= (cfg_num_stages == 8'd0) ? 8'd0 : cfg_num_stages - 8'd1;
            mask_q        <= cfg_block_mask;
            sel_q         <= cfg_sel;
            last_sel_q    <= cfg_last_sel;
            err_q         <= 1'b0;
            stage_idx_q   <= 8'd0;
            stage_start_q <= 1'b1;
            block_en_q    <= cfg_block_mask;
            // A one-stage layer starts directly on its final stage.
            output_sel_q  <= sel_map(cfg_block_mask,
                                     (cfg_num_stages <= 8'd1) ? cfg_last_sel : cfg_sel);
            busy_q        <= 1'b1;
            state_q       <= S_START;
          end
        end
        S_START: begin
          beat_cnt_q <= '0;
          state_q    <= S_STREAM;
        end
        S_STREAM: begin
          if (in_valid) begin
            if (beat_cnt_q == BEAT_LAST) begin
              beat_cnt_q  <= '0;
              drain_cnt_q <= '0;
              armed_q     <= 1'b0;
              state_q     <= S_DRAIN;
            end else begin
              beat_cnt_q <= beat_cnt_q + 10'd1;
            end
          end
        end
        S_DRAIN: begin
          // A fall only counts once res_valid has been seen high during DRAIN.
          if ((armed_q && !res_valid) || (drain_cnt_q == DRAIN_LAST)) begin
            if (!(armed_q && !res_valid)) err_q <= 1'b1;
            stage_start_q <= 1'b0;
            gap_cnt_q     <= '0;
            done_q        <= (GAP_CYC == 1) && (stage_idx_q == last_idx_q);
            state_q       <= S_GAP;
          end else begin
            drain_cnt_q <= drain_cnt_q + 10'd1;
            if (res_valid) armed_q <= 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            if (stage_idx_q == last_idx_q) begin
              block_en_q   <= '0;
              output_sel_q <= '0;
              busy_q       <= 1'b0;
              state_q      <= S_IDLE;
            end else begin
              stage_idx_q   <= stage_idx_q + 8'd1;
              stage_start_q <= 1'b1;
              output_sel_q  <= sel_map(mask_q,
                                       (stage_idx_q + 8'd1 == last_idx_q) ? last_sel_q : sel_q);
              state_q       <= S_START;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + 8'd1;
            // done shows in the final GAP cycle so busy drops right after it.
            done_q    <= (gap_cnt_q + 8'd1 == GAP_LAST) && (stage_idx_q == last_idx_q);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_max_array_sched.sv
// Directed + randomized bench for max_array_sched with a small layer model.
module tb_max_array_sched;

  localparam int NB   = 4;
  localparam int DN   = 8;
  localparam int DMAX = 16;
  localparam int GAP  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [7:0]    cfg_num_stages = '0;
  logic [NB-1:0] cfg_block_mask = '0;
  logic [1:0]    cfg_sel = '0;
  logic [1:0]    cfg_last_sel = '0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          res_valid = 1'b0;
  logic          stage_start;
  logic [NB-1:0] block_en;
  logic [2*NB-1:0] output_sel;
  logic [7:0]    stage_idx;
  logic          busy;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;

  // layer model
  logic [NB-1:0] m_mask;
  logic [1:0]    m_sel, m_lsel;
  int            m_last;
  logic          err_model = 1'b0;

  max_array_sched #(.NUM_BLOCKS(NB), .DATA_NUM(DN), .DRAIN_MAX(DMAX), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_num_stages(cfg_num_stages),
    .cfg_block_mask(cfg_block_mask), .cfg_sel(cfg_sel), .cfg_last_sel(cfg_last_sel),
    .abort(abort), .in_valid(in_valid), .in_ready(in_ready), .res_valid(res_valid),
    .stage_start(stage_start), .block_en(block_en), .output_sel(output_sel),
    .stage_idx(stage_idx), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Expected output_sel for stage s from the latched layer configuration.
  function automatic logic [2*NB-1:0] exp_sel(input int s);
    logic [1:0]      f;
    logic [2*NB-1:0] r;
    f = (s == m_last) ? m_lsel : m_sel;
    r = '0;
    for (int i = 0; i < NB; i++) if (m_mask[i]) r[2*i +: 2] = f;
    return r;
  endfunction

  task automatic check_idle();
    chk("idle_cfg_ready", cfg_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_stage_start", stage_start, 0);
    chk("idle_block_en", block_en, 0);
    chk("idle_output_sel", output_sel, 0);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_err", err, err_model);
  endtask

  task automatic start_layer(input logic [7:0] ns, input logic [NB-1:0] mask,
                             input logic [1:0] sel, input logic [1:0] lsel);
    chk("cfg_ready_before_accept", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_num_stages = ns; cfg_block_mask = mask;
    cfg_sel = sel; cfg_last_sel = lsel;
    m_mask = mask; m_sel = sel; m_lsel = lsel;
    m_last = (ns == 0) ? 0 : int'(ns) - 1;
    err_model = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic check_start(input int s);
    chk("start_stage_start", stage_start, 1);
    chk("start_block_en", block_en, m_mask);
    chk("start_output_sel", output_sel, exp_sel(s));
    chk("start_stage_idx", stage_idx, s);
    chk("start_busy", busy, 1);
    chk("start_cfg_ready", cfg_ready, 0);
    chk("start_in_ready", in_ready, 0);
    chk("start_done", done, 0);
    chk("start_err", err, err_model);
  endtask

  // pattern 0: back-to-back, 1: valid 1,0,0 repeating, 2: random
  task automatic do_stream(input int pattern);
    int   acc = 0;
    int   cyc = 0;
    logic v;
    logic ir;
    while (acc < DN && cyc < 200) begin
      ir = in_ready;
      chk("stream_in_ready", ir, 1);
      chk("stream_stage_start", stage_start, 1);
      case (pattern)
        0:       v = 1'b1;
        1:       v = ((cyc % 3) == 0);
        default: v = 1'(($urandom_range(0, 1)));
      endcase
      in_valid = v;
      res_valid = 1'($urandom_range(0, 1));      // ignored outside DRAIN
      cfg_valid = 1'($urandom_range(0, 1));      // ignored outside IDLE
      cfg_block_mask = NB'($urandom);
      cyc++;
      @(negedge clk);
      if (v && ir) acc++;
    end
    chk("beats_accepted", acc, DN);
    if (pattern == 0) chk("stream_cycles", cyc, DN);
    cfg_valid = 1'b0;
    res_valid = 1'b0;
    in_valid = 1'b1;
  endtask

  task automatic do_drain(input int d, input int h, input bit tmo);
    int n;
    n = tmo ? DMAX : d + h + 1;
    for (int k = 0; k < n; k++) begin
      chk("drain_stage_start", stage_start, 1);
      chk("drain_in_ready", in_ready, 0);
      chk("drain_err", err, err_model);
      in_valid = 1'b1;
      res_valid = (!tmo && k >= d && k < d + h);
      @(negedge clk);
    end
    res_valid = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic do_gap(input int s, input bit last);
    for (int g = 0; g < GAP; g++) begin
      chk("gap_stage_start", stage_start, 0);
      chk("gap_block_en", block_en, m_mask);
      chk("gap_output_sel", output_sel, exp_sel(s));
      chk("gap_done", done, (last && g == GAP - 1));
      chk("gap_busy", busy, 1);
      chk("gap_err", err, err_model);
      @(negedge clk);
    end
  endtask

  task automatic run_stage(input int s, input int pattern, input bit tmo, input bit fixed);
    int d, h;
    d = fixed ? 3 : int'($urandom_range(0, 3));
    h = fixed ? 8 : int'($urandom_range(1, 8));
    check_start(s);
    @(negedge clk);
    do_stream(pattern);
    do_drain(d, h, tmo);
    if (tmo) err_model = 1'b1;
    do_gap(s, s == m_last);
    $display("stage %0d/%0d pattern=%0d drain=%0d timeout=%0d", s, m_last, pattern,
             tmo ? DMAX : d + h + 1, tmo);
  endtask

  task automatic run_layer(input logic [7:0] ns, input logic [NB-1:0] mask,
                           input logic [1:0] sel, input logic [1:0] lsel,
                           input int pattern, input int tmo_stage, input bit fixed);
    start_layer(ns, mask, sel, lsel);
    for (int s = 0; s <= m_last; s++) run_stage(s, pattern, (s == tmo_stage), fixed);
    check_idle();
    @(negedge clk);
    chk("after_layer_done_low", done, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_idle();
    chk("reset_stage_idx", stage_idx, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single stage, sparse mask, fixed drain window
    run_layer(8'd1, 4'b0101, 2'b01, 2'b10, 0, -1, 1'b1);
    // 2: three stages, full mask
    run_layer(8'd3, 4'b1111, 2'b01, 2'b11, 0, -1, 1'b0);
    // 3: bubbles on the beat stream
    run_layer(8'd2, 4'b0011, 2'b10, 2'b01, 1, -1, 1'b0);
    // 4: drain timeout in stage 0, layer still completes; err clears on next accept
    run_layer(8'd2, 4'b1010, 2'b01, 2'b10, 2, 0, 1'b0);
    chk("err_sticky_in_idle", err, 1);
    run_layer(8'd0, 4'b0110, 2'b11, 2'b01, 2, -1, 1'b0);   // 0 stages treated as 1

    // 5: abort on the 4th beat
    start_layer(8'd1, 4'b0110, 2'b11, 2'b01);
    check_start(0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("abort_pre_in_ready", in_ready, 1);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    check_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      chk("abort_stays_idle", busy, 0);
    end
    // abort beats cfg_valid in IDLE
    cfg_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; abort = 1'b0;
    chk("abort_vs_cfg_ready", cfg_ready, 1);
    chk("abort_vs_cfg_busy", busy, 0);
    chk("abort_vs_cfg_stage_start", stage_start, 0);
    run_layer(8'd1, 4'b1001, 2'b10, 2'b11, 0, -1, 1'b0);

    // 6: reset in DRAIN of stage 1 (after a timeout set err)
    start_layer(8'd2, 4'b1100, 2'b01, 2'b11);
    run_stage(0, 0, 1'b1, 1'b0);
    check_start(1);
    @(negedge clk);
    do_stream(0);
    for (int k = 0; k < 4; k++) begin
      chk("pre_reset_drain", stage_start, 1);
      @(negedge clk);
    end
    rst = 1'b1; cfg_valid = 1'b1;
    err_model = 1'b0;
    @(negedge clk);
    check_idle();
    chk("midreset_stage_idx", stage_idx, 0);
    @(negedge clk);
    chk("rst_blocks_cfg_ready", cfg_ready, 1);
    chk("rst_blocks_cfg_busy", busy, 0);
    rst = 1'b0; cfg_valid = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", busy, 0);

    // Random layers
    for (int l = 0; l < 3; l++) begin
      run_layer(8'($urandom_range(1, 3)), NB'($urandom), 2'($urandom), 2'($urandom),
                2, -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/max_array_sched.md
Name: max_array_sched

Overview:
- Stage sequencer for a row of max_block reduction tiles in the glut_array datapath.
- Accepts a per-layer configuration and drives the shared stage_start, per-block block_en and per-block output_sel for every stage.
- Gates the 128-bit beat stream into the row with a valid/ready handshake, counting exactly DATA_NUM beats per stage.
- Waits for the row's max-result window to finish, then opens the next stage or reports layer completion.

Parameters:
NUM_BLOCKS, 4, number of max_block tiles controlled
DATA_NUM, 192, input beats per stage; must equal the tiles' DATA_NUM (2..1023)
DRAIN_MAX, 1023, cycles allowed in DRAIN before timeout error
GAP_CYC, 2, cycles stage_start is held low between stages (min 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cfg_valid  in  1  layer configuration offered
cfg_ready  out  1  high only in IDLE
cfg_num_stages  in  8  stages in layer; 0 treated as 1
cfg_block_mask  in  NUM_BLOCKS  block_en value for all stages
cfg_sel  in  2  output_sel for enabled blocks, non-final stages
cfg_last_sel  in  2  output_sel for enabled blocks, final stage
abort  in  1  synchronous abort, returns to IDLE
in_valid  in  1  upstream beat valid
in_ready  out  1  beat accepted when in_valid&in_ready
res_valid  in  1  OR of tiles' max-result valid (west/south atvalid with max selected)
stage_start  out  1  to all tiles
block_en  out  NUM_BLOCKS  to tiles
output_sel  out  2*NUM_BLOCKS  block i uses bits [2i+1:2i]
stage_idx  out  8  current stage, 0-based
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse after final stage
err  out  1  sticky drain timeout; cleared on next cfg accept

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE and all counters 0. Outputs: stage_start=0, block_en=0, output_sel=0, in_ready=0, stage_idx=0, busy=0, done=0, err=0, cfg_ready=1. Applies mid-operation with the same result.
- Registered outputs: all outputs except cfg_ready and in_ready are registered. cfg_ready and in_ready decode directly from the state register.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid: latch all cfg fields, clear err, stage_idx=0, go to START.
- START (1 cycle):
  - stage_start=1.
  - block_en=mask.
  - output_sel for each enabled block = (stage_idx==num_stages-1 ? last_sel : sel); disabled blocks get 2'b00.
  - Rising edge of stage_start re-initialises the tile comparators.
  - Next state: STREAM.
- STREAM:
  - stage_start=1 and in_ready=1.
  - beat_cnt (10b) increments on each accepted beat.
  - On the accepted beat with beat_cnt==DATA_NUM-1: beat_cnt->0, in_ready drops the following cycle, go to DRAIN.
  - Bubbles (in_valid=0) are legal and stall the count.
- DRAIN:
  - stage_start=1 and in_ready=0.
  - Beats offered in this state are not accepted.
  - Wait for res_valid to rise and then fall; the falling edge sends the block to GAP.
  - If DRAIN_MAX cycles elapse without that fall: set err=1, go to GAP. The layer continues.
- GAP:
  - stage_start=0 for GAP_CYC cycles; block_en and output_sel hold their values.
  - Then:
    - If stage_idx==num_stages-1: done=1 for one cycle, go to IDLE, block_en=0, output_sel=0.
    - Otherwise: stage_idx+1, go to START.
- abort (priority below rst, above everything else): next cycle state=IDLE, stage_start=0, in_ready=0, block_en=0, no done pulse. err is unchanged.
- Simultaneous events:
  - cfg_valid outside IDLE is ignored.
  - cfg_valid and abort together in IDLE: abort wins, config not taken.
  - res_valid in START or STREAM is ignored and does not pre-arm DRAIN.
- Widths: stage_idx 8b with no wrap, since num_stages ≤255 (0 treated as 1). Drain counter 10b, saturating at DRAIN_MAX.

Test Plan:
1. DATA_NUM=8, cfg stages=1, mask=4'b0101, sel=01, last_sel=10; 8 back-to-back beats; res_valid high 8 cycles after 3-cycle delay -> block_en=0101, output_sel=8'b00100010, in_ready high exactly 8 cycles, stage_start low GAP_CYC cycles then done pulse, busy falls the cycle after done.
2. stages=3, mask=4'b1111, sel=01, last_sel=11 -> stage_idx 0,1,2; output_sel=8'h55 for stages 0-1 and 8'hFF for stage 2; stage_start shows three rising edges each preceded by ≥2 low cycles; done once.
3. Beats with bubbles (valid pattern 1,0,0,1 ...) plus beats offered during DRAIN -> exactly 8 accepted per stage; no acceptance outside STREAM.
4. DRAIN_MAX=16 and res_valid never asserted -> err=1 at cycle 16 of DRAIN; layer still completes with done; err clears on next cfg accept.
5. abort asserted on the 4th STREAM beat -> next cycle IDLE, stage_start=0, cfg_ready=1, no done; new cfg accepted and runs cleanly.
6. rst asserted in DRAIN of stage 1 -> all outputs at reset values on the following cycle; cfg_valid held with rst=1 is not accepted.
